// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / multiply-accumulate / divide engine with a 2*WIDTH result
// behind a valid/ready handshake; signed and unsigned operands, defined div-by-zero behaviour.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result_lo,
    output logic [WIDTH-1:0]   result_hi,
    output logic [2:0]         flags
);
    localparam int W2 = 2 * WIDTH;
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_MLA = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v);
        neg_w2 = (~v) + {{(W2-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            mag = neg_w(v);
        end else begin
            mag = v;
        end
    endfunction

    state_t             state_r, state_s;
    logic               in_ready_r, out_valid_r;
    logic [1:0]         op_r;
    logic               dbz_r, neg_res_r, neg_rem_r;
    logic [W2-1:0]      acc_r;
    logic [WIDTH-1:0]   opnd_r;
    logic [W2-1:0]      work_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   result_lo_r, result_hi_r;
    logic [2:0]         flags_r;

    logic               dbz_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [W2-1:0]      mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic [W2-1:0]      div_next_s;
    logic [W2-1:0]      prod_s, mla_s;
    logic [WIDTH-1:0]   quo_s, rem_s;
    logic [WIDTH-1:0]   fix_lo_s, fix_hi_s;
    logic [2:0]         fix_flags_s;

    assign dbz_s     = (op == OP_DIV) && (b == {WIDTH{1'b0}});
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result_lo = result_lo_r;
    assign result_hi = result_hi_r;
    assign flags     = flags_r;

    // State register with handshake outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Next-state decode; div-by-zero and the reserved op skip the iteration phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if ((op == 2'b11) || dbz_s) begin
                        state_s = FIX;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == CNT_W'(1)) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // One shift-add step (hi:lo product) and one restoring-divide step (hi=rem, lo=quotient).
    always_comb begin
        mul_sum_s   = {1'b0, work_r[W2-1:WIDTH]} +
                      (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, work_r[WIDTH-1:1]};
        div_shift_s = {work_r[W2-1:WIDTH], work_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
        if (div_ge_s) begin
            div_next_s = {div_diff_s, work_r[WIDTH-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and flag generation; a wrapped most-negative quotient falls out naturally.
    always_comb begin
        prod_s      = neg_res_r ? neg_w2(work_r) : work_r;
        mla_s       = prod_s + acc_r;
        quo_s       = neg_res_r ? neg_w(work_r[WIDTH-1:0]) : work_r[WIDTH-1:0];
        rem_s       = neg_rem_r ? neg_w(work_r[W2-1:WIDTH]) : work_r[W2-1:WIDTH];
        fix_lo_s    = {WIDTH{1'b0}};
        fix_hi_s    = {WIDTH{1'b0}};
        fix_flags_s = 3'b000;
        case (op_r)
            OP_MUL: begin
                {fix_hi_s, fix_lo_s} = prod_s;
                fix_flags_s = {1'b0, prod_s[W2-1], prod_s == {W2{1'b0}}};
            end
            OP_MLA: begin
                {fix_hi_s, fix_lo_s} = mla_s;
                fix_flags_s = {1'b0, mla_s[W2-1], mla_s == {W2{1'b0}}};
            end
            OP_DIV: begin
                if (dbz_r) begin
                    fix_hi_s    = work_r[W2-1:WIDTH];
                    fix_flags_s = 3'b101;
                end else begin
                    fix_lo_s    = quo_s;
                    fix_hi_s    = rem_s;
                    fix_flags_s = {1'b0, quo_s[WIDTH-1], quo_s == {WIDTH{1'b0}}};
                end
            end
            default: begin
                fix_lo_s    = {WIDTH{1'b0}};
                fix_hi_s    = {WIDTH{1'b0}};
                fix_flags_s = 3'b000;
            end
        endcase
    end

    // Operand capture at acceptance, iteration in RUN, result capture on the FIX->DONE edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r        <= 2'b00;
            dbz_r       <= 1'b0;
            neg_res_r   <= 1'b0;
            neg_rem_r   <= 1'b0;
            acc_r       <= {W2{1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            work_r      <= {W2{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            result_lo_r <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            flags_r     <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r      <= op;
                        dbz_r     <= dbz_s;
                        neg_res_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_r <= is_signed & a[WIDTH-1];
                        acc_r     <= acc;
                        cnt_r     <= CNT_W'(WIDTH);
                        if (op == OP_DIV) begin
                            opnd_r <= mag(b, is_signed);
                            // Divide-by-zero parks the raw dividend where the remainder is read.
                            work_r <= dbz_s ? {a, {WIDTH{1'b0}}}
                                            : {{WIDTH{1'b0}}, mag(a, is_signed)};
                        end else begin
                            opnd_r <= mag(a, is_signed);
                            work_r <= {{WIDTH{1'b0}}, mag(b, is_signed)};
                        end
                    end
                end
                RUN: begin
                    cnt_r  <= cnt_r - CNT_W'(1);
                    work_r <= (op_r == OP_DIV) ? div_next_s : mul_next_s;
                end
                FIX: begin
                    result_lo_r <= fix_lo_s;
                    result_hi_r <= fix_hi_s;
                    flags_r     <= fix_flags_s;
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: randomized and directed requests checked against
// a plain-arithmetic reference model, with latency, throughput, backpressure and reset checks.
module tb_muldiv_unit;
    localparam int W = 32;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic [2:0]  fl;
        int          lat;
        int          req_cyc;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] acc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [2:0]  flags;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   bp_mode  = 0;
    exp_t sb[$];

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model written from the arithmetic definition of each operation.
    function automatic exp_t model(input logic [1:0] o, input logic s, input logic [31:0] x,
                                   input logic [31:0] y, input logic [63:0] ad);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        logic [31:0] q, r;
        sx = s ? longint'($signed(x)) : longint'({32'b0, x});
        sy = s ? longint'($signed(y)) : longint'({32'b0, y});
        p  = 64'(sx * sy);
        e.req_cyc = 0;
        e.lat = W + 2;
        case (o)
            2'b00, 2'b01: begin
                if (o == 2'b01) p = p + ad;
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.fl = {1'b0, p[63], p == 64'd0};
            end
            2'b10: begin
                if (y == 32'd0) begin
                    q = 32'd0;
                    r = x;
                    e.lat = 2;
                end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    q = 32'(sx / sy);
                    r = 32'(sx % sy);
                end
                e.lo = q;
                e.hi = r;
                e.fl = {y == 32'd0, q[31], q == 32'd0};
            end
            default: begin
                e.lo = 32'd0;
                e.hi = 32'd0;
                e.fl = 3'b000;
                e.lat = 2;
            end
        endcase
        return e;
    endfunction

    task automatic scramble();
        op        = 2'($urandom_range(0, 3));
        is_signed = 1'($urandom_range(0, 1));
        a         = $urandom;
        b         = $urandom;
        acc       = {$urandom, $urandom};
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'd0 - 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] ad, output int acc_cyc);
        exp_t e;
        int   k;
        e = model(o, s, x, y, ad);
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            scramble();
            @(negedge clk);
            k++;
        end
        acc_cyc = cyc;
        check("issue_in_ready", 64'(in_ready), 64'd1);
        if (in_ready) begin
            op        = o;
            is_signed = s;
            a         = x;
            b         = y;
            acc       = ad;
            in_valid  = 1'b1;
            e.req_cyc = cyc;
            @(posedge clk);
            sb.push_back(e);
            #1;
            in_valid = 1'b0;
            scramble();
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000 && sb.size() > 0; i++) begin
            @(negedge clk);
            scramble();
        end
        repeat (2) @(negedge clk);
        check("drain_queue_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops one expectation per result, checks stability while held, drives out_ready.
    initial begin : monitor
        exp_t cur;
        bit   seen;
        bit   expect_idle;
        int   hold;
        seen        = 1'b0;
        expect_idle = 1'b0;
        hold        = 0;
        out_ready   = 1'b1;
        forever begin
            @(negedge clk);
            if (expect_idle) begin
                check("handoff_out_valid_low", 64'(out_valid), 64'd0);
                check("handoff_in_ready_high", 64'(in_ready), 64'd1);
                expect_idle = 1'b0;
            end
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: lo=%h hi=%h with empty queue", result_lo, result_hi);
                        cur.lo = result_lo;
                        cur.hi = result_hi;
                        cur.fl = flags;
                    end else begin
                        cur = sb.pop_front();
                        check("latency", 64'(cyc - cur.req_cyc), 64'(cur.lat));
                    end
                    hold = (bp_mode == 2) ? 10 : ((bp_mode == 1) ? $urandom_range(0, 3) : 0);
                end
                check("result_lo", 64'(result_lo), 64'(cur.lo));
                check("result_hi", 64'(result_hi), 64'(cur.hi));
                check("flags", 64'(flags), 64'(cur.fl));
                check("in_ready_low_in_done", 64'(in_ready), 64'd0);
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready   = 1'b1;
                    expect_idle = 1'b1;
                end
            end else begin
                seen      = 1'b0;
                out_ready = (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    initial begin : main
        int c1, c2;
        reset    = 1'b1;
        in_valid = 1'b0;
        scramble();
        repeat (2) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", {result_hi, result_lo}, 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        reset = 1'b0;

        // Directed cases, back-to-back with out_ready held high.
        issue(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, c1);
        issue(2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7, 64'd0, c2);
        check("throughput", 64'(c2 - c1), 64'(W + 3));
        issue(2'b01, 1'b1, 32'hFFFF_FFFE, 32'd50, 64'd100, c1);
        issue(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 64'd0, c1);
        issue(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, c1);
        issue(2'b10, 1'b1, 32'd5, 32'd0, 64'd0, c1);
        issue(2'b10, 1'b0, 32'd5, 32'd0, 64'd0, c1);
        issue(2'b11, 1'b1, 32'd9, 32'd3, 64'd7, c1);
        drain();

        // Backpressure: result held for 10 cycles with out_ready low.
        bp_mode = 2;
        issue(2'b00, 1'b0, $urandom, $urandom, 64'd0, c1);
        drain();
        bp_mode = 0;

        // Reset in the 5th RUN cycle aborts the operation.
        issue(2'b00, 1'b0, 32'd123, 32'd456, 64'd0, c1);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_result", {result_hi, result_lo}, 64'd0);
        check("abort_flags", 64'(flags), 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        issue(2'b00, 1'b0, 32'd6, 32'd7, 64'd0, c1);
        drain();

        // Randomized mix with random backpressure.
        bp_mode = 1;
        for (int n = 0; n < 60; n++) begin
            issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
                  {$urandom, $urandom}, c1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
